// File: rtl/lsu_req_pkg.sv
// Shared opcodes, FSM encoding and decode helpers for the load/store initiator.
package lsu_req_pkg;

    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpLb    = 6'h20;
    localparam logic [5:0] OpLbu   = 6'h24;
    localparam logic [5:0] OpSb    = 6'h28;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] FnJalr  = 6'h09;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } lsu_state_e;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OpLw) || (op == OpSw) || (op == OpLb) || (op == OpLbu) || (op == OpSb);
    endfunction

    // Word ops must be naturally aligned; byte ops never fault.
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lane);
        return ((op == OpLw) || (op == OpSw)) && (lane != 2'd0);
    endfunction

endpackage

// File: rtl/lsu_req_fmt.sv
// Byte-lane formatting: builds request lanes/data and extracts load results.
module lsu_req_fmt
    import lsu_req_pkg::*;
(
    input  logic [5:0]  req_op,
    input  logic [1:0]  req_lane,
    input  logic [31:0] store_data,
    input  logic [5:0]  rsp_op,
    input  logic [1:0]  rsp_lane,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        we,
    output logic [31:0] load_data
);

    logic [7:0] rsp_byte;

    // Request side: lane enables and write data for the incoming op.
    always_comb begin
        be    = 4'h0;
        wdata = 32'h0;
        we    = 1'b0;
        case (req_op)
            OpSw: begin
                be    = 4'hF;
                wdata = store_data;
                we    = 1'b1;
            end
            OpSb: begin
                be    = 4'b0001 << req_lane;
                wdata = {4{store_data[7:0]}};
                we    = 1'b1;
            end
            OpLw:        be = 4'hF;
            OpLb, OpLbu: be = 4'b0001 << req_lane;
            default: ;
        endcase
    end

    // Response side: pick the little-endian byte lane.
    always_comb begin
        rsp_byte = rdata[7:0];
        case (rsp_lane)
            2'd0: rsp_byte = rdata[7:0];
            2'd1: rsp_byte = rdata[15:8];
            2'd2: rsp_byte = rdata[23:16];
            2'd3: rsp_byte = rdata[31:24];
            default: ;
        endcase
    end

    // Response side: extend to the write-back value; stores complete with zero.
    always_comb begin
        load_data = 32'h0;
        case (rsp_op)
            OpLw:  load_data = rdata;
            OpLb:  load_data = {{24{rsp_byte[7]}}, rsp_byte};
            OpLbu: load_data = {24'h0, rsp_byte};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_req.sv
// Load/store initiator: one req/gnt transaction per memory op, stalls while busy.
module lsu_req
    import lsu_req_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned ADDR_W  = 30
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [31:0]       Ins,
    input  logic [31:0]       Result,
    input  logic [31:0]       Rdata2,
    input  logic [31:0]       nextPC,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [31:0]       Wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    lsu_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [31:0]       data_q, data_d;
    logic [5:0]        op_q, op_d;
    logic [1:0]        lane_q, lane_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic        mem_op;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic        fmt_we;
    logic [31:0] fmt_load;
    logic        unused_ins;

    assign op         = Ins[31:26];
    assign funct      = Ins[5:0];
    assign mem_op     = is_mem_op(op);
    assign unused_ins = ^Ins[25:6];

    lsu_req_fmt u_fmt (
        .req_op     (op),
        .req_lane   (Result[1:0]),
        .store_data (Rdata2),
        .rsp_op     (op_q),
        .rsp_lane   (lane_q),
        .rdata      (mem_rdata),
        .be         (fmt_be),
        .wdata      (fmt_wdata),
        .we         (fmt_we),
        .load_data  (fmt_load)
    );

    // Next-state: accept in IDLE, handshake in REQ, await response in WAIT, pulse in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        data_d  = data_q;
        op_d    = op_q;
        lane_d  = lane_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (start && mem_op) begin
                    op_d   = op;
                    lane_d = Result[1:0];
                    data_d = 32'h0;
                    cnt_d  = '0;
                    if (is_misaligned(op, Result[1:0])) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        err_d   = 1'b0;
                        we_d    = fmt_we;
                        addr_d  = Result[ADDR_W+1:2];
                        be_d    = fmt_be;
                        wdata_d = fmt_wdata;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (mem_gnt) begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                // A response on the final budget cycle still counts as completion.
                if (mem_rvalid) begin
                    data_d  = fmt_load;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and request registers; reset abandons any in-flight transaction.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= 32'h0;
            op_q    <= 6'h0;
            lane_q  <= 2'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            data_q  <= data_d;
            op_q    <= op_d;
            lane_q  <= lane_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    // Outputs: memory port from registers, pipeline control from state and current op.
    always_comb begin
        mem_req   = (state_q == StReq);
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_be    = be_q;
        mem_wdata = wdata_q;
        done      = (state_q == StDone);
        err       = (state_q == StDone) && err_q;
        stall     = (state_q == StReq) || (state_q == StWait) ||
                    ((state_q == StIdle) && start && mem_op);
        if (state_q == StDone) begin
            Wdata = data_q;
        end else if ((op == OpJal) || ((op == OpRtype) && (funct == FnJalr))) begin
            Wdata = nextPC;
        end else begin
            Wdata = Result;
        end
    end

endmodule

// File: tb/tb_lsu_req.sv
// Directed bench for lsu_req with hand-computed expectations.
module tb_lsu_req;
    import lsu_req_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [31:0] Ins, Result, Rdata2, nextPC;
    logic        stall, done, err;
    logic [31:0] Wdata;
    logic        mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int n_pass  = 0;
    int n_total = 0;

    lsu_req #(.TIMEOUT(8), .ADDR_W(30)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .Ins        (Ins),
        .Result     (Result),
        .Rdata2     (Rdata2),
        .nextPC     (nextPC),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .Wdata      (Wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Full load with immediate gnt and rvalid one cycle later.
    task automatic do_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_w);
        start = 1'b1; Ins = {op, 26'h0}; Result = addr;
        #1 chk({tag, "_stall0"}, {31'h0, stall}, 32'd1);
        tick();
        start = 1'b0; mem_gnt = 1'b1;
        #1 chk({tag, "_req"}, {31'h0, mem_req}, 32'd1);
        chk({tag, "_addr"}, {2'b0, mem_addr}, {2'b0, addr[31:2]});
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
        #1;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1 chk({tag, "_done"}, {30'h0, done, err}, 32'd2);
        chk({tag, "_wdata"}, Wdata, exp_w);
        tick();
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; Ins = 32'h0; Result = 32'h0; Rdata2 = 32'h0;
        nextPC = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #12;
        chk("rst_req", {31'h0, mem_req}, 32'd0);
        chk("rst_done_err", {30'h0, done, err}, 32'd0);
        chk("rst_addr_be", {mem_addr, mem_be[1:0]}, 32'd0);
        chk("rst_be_wdata", {mem_be, mem_wdata[27:0]}, 32'd0);
        chk("rst_stall_idle", {31'h0, stall}, 32'd0);
        start = 1'b1; Ins = {OpLw, 26'h0};
        #1 chk("rst_stall_comb", {31'h0, stall}, 32'd1);
        start = 1'b0;
        tick();
        RST = 1'b0;
        tick();

        // LW 0x10: minimum latency path.
        start = 1'b1; Ins = {OpLw, 26'h0}; Result = 32'h10;
        #1 chk("lw_c0_stall", {31'h0, stall}, 32'd1);
        chk("lw_c0_done", {31'h0, done}, 32'd0);
        tick();
        start = 1'b0; mem_gnt = 1'b1;
        #1 chk("lw_c1_req", {31'h0, mem_req}, 32'd1);
        chk("lw_c1_addr", {2'b0, mem_addr}, 32'd4);
        chk("lw_c1_be", {27'h0, mem_we, mem_be}, 32'h0F);
        chk("lw_c1_stall", {31'h0, stall}, 32'd1);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        #1 chk("lw_c2_req", {31'h0, mem_req}, 32'd0);
        chk("lw_c2_stall", {31'h0, stall}, 32'd1);
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1 chk("lw_c3_done", {30'h0, done, err}, 32'd2);
        chk("lw_c3_wdata", Wdata, 32'h12345678);
        chk("lw_c3_stall", {31'h0, stall}, 32'd0);
        tick();
        chk("lw_c4_done", {31'h0, done}, 32'd0);

        // SB 0x13 with gnt held off three cycles.
        start = 1'b1; Ins = {OpSb, 26'h0}; Result = 32'h13; Rdata2 = 32'h123456AB;
        #1;
        tick();
        start = 1'b0; Rdata2 = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("sb_hold_req", {31'h0, mem_req}, 32'd1);
            chk("sb_hold_be", {26'h0, mem_we, mem_be}, 32'h18);
            chk("sb_hold_wdata", mem_wdata, 32'hABABABAB);
            chk("sb_hold_addr", {2'b0, mem_addr}, 32'd4);
            tick();
        end
        mem_gnt = 1'b1;
        #1 chk("sb_gnt_req", {31'h0, mem_req}, 32'd1);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1;
        #1 chk("sb_wait_req", {31'h0, mem_req}, 32'd0);
        tick();
        mem_rvalid = 1'b0;
        #1 chk("sb_done", {30'h0, done, err}, 32'd2);
        chk("sb_wdata", Wdata, 32'h0);
        tick();

        // Byte loads from lane 2.
        do_load("lb", OpLb, 32'h22, 32'h00F50000, 32'hFFFFFFF5);
        do_load("lbu", OpLbu, 32'h22, 32'h00F50000, 32'h000000F5);

        // Misaligned LW: immediate error, no request.
        start = 1'b1; Ins = {OpLw, 26'h0}; Result = 32'h6;
        #1 chk("mis_c0_stall", {31'h0, stall}, 32'd1);
        tick();
        start = 1'b0;
        #1 chk("mis_c1_req", {31'h0, mem_req}, 32'd0);
        chk("mis_c1_done_err", {30'h0, done, err}, 32'd3);
        chk("mis_c1_wdata", Wdata, 32'h0);
        tick();
        chk("mis_c2_done_err", {30'h0, done, err}, 32'd0);

        // Non-memory pass-through.
        start = 1'b1; Ins = {OpRtype, 20'h0, 6'h21}; Result = 32'h7; nextPC = 32'h40;
        #1 chk("addu_wdata", Wdata, 32'h7);
        chk("addu_stall_done", {30'h0, stall, done}, 32'd0);
        Ins = {OpJal, 26'h0};
        #1 chk("jal_wdata", Wdata, 32'h40);
        Ins = {OpRtype, 20'h0, FnJalr};
        #1 chk("jalr_wdata", Wdata, 32'h40);
        tick();
        chk("nonmem_req", {31'h0, mem_req}, 32'd0);
        start = 1'b0;

        // Timeout: gnt given, no response.
        start = 1'b1; Ins = {OpLw, 26'h0}; Result = 32'h30;
        #1;
        tick();
        start = 1'b0; mem_gnt = 1'b1;
        #1 chk("to_c1_req", {31'h0, mem_req}, 32'd1);
        tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1 chk("to_wait", {30'h0, stall, done}, 32'd2);
            tick();
        end
        #1 chk("to_done_err", {30'h0, done, err}, 32'd3);
        chk("to_wdata", Wdata, 32'h0);
        chk("to_req", {31'h0, mem_req}, 32'd0);
        tick();
        do_load("after_to", OpLw, 32'h44, 32'hA5A5C3C3, 32'hA5A5C3C3);

        // Reset while waiting for the response.
        start = 1'b1; Ins = {OpLw, 26'h0}; Result = 32'h40;
        #1;
        tick();
        start = 1'b0; mem_gnt = 1'b1;
        #1;
        tick();
        mem_gnt = 1'b0; RST = 1'b1;
        #1 chk("rw_req", {31'h0, mem_req}, 32'd0);
        chk("rw_done_err", {30'h0, done, err}, 32'd0);
        chk("rw_stall", {31'h0, stall}, 32'd0);
        chk("rw_addr", {2'b0, mem_addr}, 32'd0);
        tick();
        RST = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1 chk("rw_late_rsp", {30'h0, done, stall}, 32'd0);
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1 chk("rw_late_done", {31'h0, done}, 32'd0);
        tick();
        do_load("after_rst", OpLw, 32'h8, 32'hCAFEF00D, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lsu_req.md
Name: lsu_req

Overview:
- Load/store initiator for the MIPS datapath, placed between the execute result and a handshaked data memory.
- Latches a memory instruction's address and store data, then issues one request with a req/gnt handshake.
- Waits for the memory response and returns the write-back value.
- Stalls the pipeline while a transaction is outstanding.
- Non-memory instructions pass through combinationally, with the same write-back mux rules as the datapath: Result by default, nextPC for JAL/JALR.

Parameters:
- TIMEOUT, 64, max cycles spent in REQ+WAIT before the transaction is aborted with an error.
- ADDR_W, 30, memory word-address width; drives mem_addr = addr[31:2].

Ports:
- CLK  in  1  single clock; all state changes on posedge.
- RST  in  1  asynchronous active-high reset.
- start  in  1  execute stage presents a valid instruction this cycle.
- Ins  in  32  instruction; op = Ins[31:26], funct = Ins[5:0].
- Result  in  32  ALU result; byte address for memory ops.
- Rdata2  in  32  store data.
- nextPC  in  32  return address for JAL/JALR.
- stall  out  1  freeze the upstream pipeline.
- done  out  1  one-cycle pulse; Wdata holds the load/store completion value.
- err  out  1  one-cycle pulse with done on a misaligned access or timeout.
- Wdata  out  32  write-back data.
- mem_req  out  1  request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word address.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  write data.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  response; read data valid or write acknowledged.
- mem_rdata  in  32  read data.

Behaviour:
- Memory ops are LW, SW, LB, LBU, SB. Everything else is a non-memory op.
- Non-memory op: stall=0, done=0. Wdata = nextPC if op==JAL or (op==RTYPE and funct==JALR), else Result.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, start with a memory op:
  - Register op, addr=Result, and data. stall=1 combinationally.
  - Misaligned access (LW/SW with addr[1:0]!=0) → DONE with err latched; no mem_req issued.
  - Aligned access → REQ.
- REQ:
  - mem_req=1. mem_addr, mem_we, mem_be and mem_wdata are registered and stable until gnt.
  - mem_gnt=1 → WAIT. mem_req drops next cycle.
- WAIT:
  - mem_rvalid=1 → DONE, capturing the formatted load data.
  - An rvalid arriving in the same cycle as gnt is ignored; the response must come at least one cycle after gnt.
- DONE:
  - stall=0, done=1, err as latched. Wdata = captured value (0 for stores and errors).
  - Next state IDLE. A start in DONE is not accepted; upstream re-presents it in IDLE.
- stall=1 in REQ and WAIT, and in IDLE when start carries a memory op. Otherwise stall=0.
- Timeout counter:
  - Cleared on entry to REQ; increments in REQ and WAIT.
  - Reaching TIMEOUT-1 without completion → DONE with err=1, Wdata=0. mem_req drops.
- Byte lanes are little-endian; lane = addr[1:0].
  - LB: sign-extend mem_rdata[8*lane+7 : 8*lane].
  - LBU: zero-extend the same byte.
  - SB: mem_be = 4'b0001 << lane, mem_wdata = {4{Rdata2[7:0]}}.
  - LW/SW: mem_be = 4'hF.
  - Loads drive mem_wdata = 0.
- Minimum latency: start cycle 0, REQ cycle 1 (with gnt), WAIT cycle 2 (with rvalid), done in cycle 3.
- Reset, including mid-transaction:
  - State=IDLE, counter=0, captured data=0.
  - mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, done=0, err=0.
  - stall follows start/Ins combinationally.
  - A response arriving after reset is ignored.

Decomposition:
- Opcodes (LW=6'h23, SW=6'h2B, LB=6'h20, LBU=6'h24, SB=6'h28, JAL=6'h03, RTYPE=6'h00) and JALR funct (6'h09) live in common_param.vh.
- FSM state encodings also go in common_param.vh.
- One sub-module: lsu_fmt, combinational. It builds be/wdata from op/lane/data and extracts and extends load data from rdata/lane.

Test Plan:
- LW addr 0x10, gnt at once, rvalid one cycle later with 0x12345678: mem_addr=4, be=F, done in cycle 3, Wdata=0x12345678, stall high in cycles 0-2.
- SB addr 0x13, Rdata2=0xAB, gnt delayed 3 cycles: req held stable, be=4'b1000, wdata=0xABABABAB, done with Wdata=0.
- LB/LBU addr 0x22, rdata=0x00F50000: LB gives Wdata=0xFFFFFFF5, LBU gives 0x000000F5.
- LW addr 0x6: no mem_req, done+err in cycle 1, Wdata=0. ADDU with Result=7 gives Wdata=7 and stall=0. JAL with nextPC=0x40 gives Wdata=0x40.
- TIMEOUT=8 with gnt given but no rvalid: done+err after 8 REQ/WAIT cycles, Wdata=0, FSM returns to IDLE and the next LW completes normally.
- RST asserted in WAIT: mem_req/done/err go 0 immediately; a later rvalid is ignored; the next start begins from IDLE.
